uart_rx_cfg: RTL

Parametrised, runtime-configurable UART receiver. It is the successor to the fixed 8N1 receiver in the UART block. It adds 5..MaxDataBits data bits, optional even/odd parity, 1 or 2 stop bits, false-start rejection, per-character parity/framing error flags stored in the FIFO, and a sticky overrun flag. It sits between the pad-side serial input and the register interface that pops received characters.

---
 rtl/uart_rx_cfg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..MaxDataBits data bits, optional parity,
// 1/2 stop bits, false-start rejection and a first-word fall-through character FIFO.
module uart_rx_cfg #(
  parameter int FifoDepth   = 4,
  parameter int BaudCycBits = 16,
  parameter int MaxDataBits = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [BaudCycBits-1:0]       c_baud_cyc,
  input  logic [3:0]                   c_data_bits,
  input  logic                         c_parity_en,
  input  logic                         c_parity_odd,
  input  logic                         c_two_stop,
  input  logic                         i_rx,
  output logic                         o_busy,
  output logic                         o_fifo_empty,
  output logic                         o_fifo_full,
  output logic [$clog2(FifoDepth):0]   o_fifo_level,
  input  logic                         i_fifo_read,
  output logic [MaxDataBits-1:0]       o_fifo_rdata,
  output logic                         o_fifo_perr,
  output logic                         o_fifo_ferr,
  output logic                         o_overrun,
  input  logic                         i_clr_overrun
);
  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam int EW = MaxDataBits + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  // state is the observable FSM state for bound checkers
  state_t state, state_nx;

  logic                   rx_m, rx_s;
  logic [BaudCycBits-1:0] cyc_cnt, cfg_baud;
  logic [3:0]             cfg_bits, bit_cnt;
  logic                   cfg_par, cfg_odd, cfg_two;
  logic [MaxDataBits-1:0] data;
  logic                   par_acc, perr, ferr, ferr_nx;
  logic                   wait_high, start, push;
  logic [BaudCycBits:0]   half;
  logic                   samp, bend;

  assign half = ({1'b0, cfg_baud} + {{BaudCycBits{1'b0}}, 1'b1}) >> 1;
  assign samp = (state != IDLE) && ({1'b0, cyc_cnt} == half);
  assign bend = (cyc_cnt == '0);
  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    push     = 1'b0;
    ferr_nx  = ferr;
    case (state)
      IDLE:   if (!rx_s && !wait_high) begin
                state_nx = START;
                start    = 1'b1;
              end
      START:  if (samp && rx_s) state_nx = IDLE;
              else if (bend)    state_nx = DATA;
      DATA:   if (bend && bit_cnt == cfg_bits - 4'd1) state_nx = cfg_par ? PARITY : STOP1;
      PARITY: if (bend) state_nx = STOP1;
      STOP1:  if (samp) begin
                ferr_nx = ~rx_s;
                if (!cfg_two) begin
                  push     = 1'b1;
                  state_nx = IDLE;
                end
              end else if (bend) begin
                state_nx = STOP2;
              end
      STOP2:  if (samp) begin
                ferr_nx  = ferr | ~rx_s;
                push     = 1'b1;
                state_nx = IDLE;
              end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      cyc_cnt   <= '0;
      cfg_baud  <= '0;
      cfg_bits  <= 4'd8;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
      cfg_two   <= 1'b0;
      bit_cnt   <= '0;
      data      <= '0;
      par_acc   <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      ferr <= ferr_nx;
      if (state == IDLE) begin
        cfg_baud <= c_baud_cyc;
        cfg_bits <= c_data_bits;
        cfg_par  <= c_parity_en;
        cfg_odd  <= c_parity_odd;
        cfg_two  <= c_two_stop;
      end
      if (start) begin
        cyc_cnt <= c_baud_cyc;
        bit_cnt <= '0;
        data    <= '0;
        par_acc <= 1'b0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
      end else if (state != IDLE) begin
        cyc_cnt <= bend ? cfg_baud : cyc_cnt - 1'b1;
      end
      if (state == DATA && samp) begin
        for (int i = 0; i < MaxDataBits; i++)
          if (bit_cnt == 4'(i)) data[i] <= rx_s;
        par_acc <= par_acc ^ rx_s;
      end
      if (state == DATA && bend && bit_cnt != cfg_bits - 4'd1) bit_cnt <= bit_cnt + 4'd1;
      if (state == PARITY && samp) perr <= par_acc ^ rx_s ^ cfg_odd;
      // A break leaves the line low; only a high level re-arms start detection.
      if (push && !rx_s) wait_high <= 1'b1;
      else if (rx_s)     wait_high <= 1'b0;
    end
  end

  logic [EW-1:0] mem [FifoDepth];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          pop;

  assign o_fifo_level = wr_ptr - rd_ptr;
  assign o_fifo_empty = (o_fifo_level == '0);
  assign o_fifo_full  = (o_fifo_level == LW'(FifoDepth));
  assign pop          = i_fifo_read && !o_fifo_empty;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign o_fifo_rdata = o_fifo_empty ? '0 : head[MaxDataBits-1:0];
  assign o_fifo_perr  = o_fifo_empty ? 1'b0 : head[MaxDataBits];
  assign o_fifo_ferr  = o_fifo_empty ? 1'b0 : head[MaxDataBits+1];

  always_ff @(posedge i_clk) begin
    if (push && !o_fifo_full) mem[wr_ptr[AW-1:0]] <= {ferr_nx, perr, data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (push && !o_fifo_full) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Fullness is judged before any same-cycle pop, so a read cannot rescue the character.
      if (push && o_fifo_full) o_overrun <= 1'b1;
      else if (i_clr_overrun)  o_overrun <= 1'b0;
    end
  end
endmodule
